// File: rtl/rle_vli_encoder.sv
// JPEG run-length / VLI symbol builder: one zigzag coefficient in, (run, size, bits) symbols out.
// ZRL and EOB symbols are inserted following baseline JPEG rules.
module rle_vli_encoder #(
  parameter int BLOCK_LEN = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_coef,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_run,
  output logic [3:0]  out_size,
  output logic [10:0] out_bits,
  output logic        out_is_dc,
  output logic        out_last
);

  localparam int IW = $clog2(BLOCK_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_LEN - 1);

  typedef enum logic {S_RUN, S_ZRL} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   run;
  logic [IW-1:0]   zrl_pend;
  logic [3:0]      lat_run;
  logic [3:0]      lat_size;
  logic [10:0]     lat_bits;
  logic            lat_last;

  logic            slot_free;
  logic            accept;
  logic            is_last;
  logic            coef_zero;
  logic [11:0]     sat;
  logic [11:0]     adj;
  logic [10:0]     mag;
  logic [10:0]     mask;
  logic [10:0]     vli_bits;
  logic [3:0]      vli_size;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = !reset && (state == S_RUN) && slot_free;
  assign accept    = in_valid && in_ready;
  assign is_last   = (idx == LAST_IDX);
  assign coef_zero = (in_coef == 12'd0);

  // -2048 has no 11-bit magnitude, so it is clamped to -2047 before sizing.
  always_comb begin
    sat = (in_coef == 12'h800) ? 12'h801 : in_coef;
    mag = sat[11] ? 11'(-sat) : sat[10:0];
    vli_size = 4'd0;
    for (int i = 0; i < 11; i++) begin
      if (mag[i]) vli_size = 4'(i + 1);
    end
    mask     = (11'd1 << vli_size) - 11'd1;
    adj      = sat - 12'd1;
    vli_bits = (sat[11] ? adj[10:0] : sat[10:0]) & mask;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_RUN;
      idx       <= '0;
      run       <= '0;
      zrl_pend  <= '0;
      lat_run   <= 4'd0;
      lat_size  <= 4'd0;
      lat_bits  <= 11'd0;
      lat_last  <= 1'b0;
      out_valid <= 1'b0;
      out_run   <= 4'd0;
      out_size  <= 4'd0;
      out_bits  <= 11'd0;
      out_is_dc <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        S_RUN: begin
          if (accept) begin
            idx <= is_last ? '0 : idx + 1'b1;
            run <= '0;
            if (idx == '0) begin
              out_valid <= 1'b1; out_run <= 4'd0; out_size <= vli_size;
              out_bits <= vli_bits; out_is_dc <= 1'b1; out_last <= 1'b0;
            end else if (coef_zero) begin
              if (is_last) begin
                out_valid <= 1'b1; out_run <= 4'd0; out_size <= 4'd0;
                out_bits <= 11'd0; out_is_dc <= 1'b0; out_last <= 1'b1;
              end else begin
                run <= run + 1'b1;
              end
            end else if (run < 16) begin
              out_valid <= 1'b1; out_run <= run[3:0]; out_size <= vli_size;
              out_bits <= vli_bits; out_is_dc <= 1'b0; out_last <= is_last;
            end else begin
              // First ZRL leaves on the accepting edge; the rest drain in S_ZRL.
              out_valid <= 1'b1; out_run <= 4'd15; out_size <= 4'd0;
              out_bits <= 11'd0; out_is_dc <= 1'b0; out_last <= 1'b0;
              zrl_pend  <= (run >> 4) - 1'b1;
              lat_run   <= run[3:0];
              lat_size  <= vli_size;
              lat_bits  <= vli_bits;
              lat_last  <= is_last;
              state     <= S_ZRL;
            end
          end
        end
        S_ZRL: begin
          if (slot_free) begin
            out_valid <= 1'b1;
            out_is_dc <= 1'b0;
            if (zrl_pend != '0) begin
              out_run <= 4'd15; out_size <= 4'd0; out_bits <= 11'd0; out_last <= 1'b0;
              zrl_pend <= zrl_pend - 1'b1;
            end else begin
              out_run <= lat_run; out_size <= lat_size; out_bits <= lat_bits; out_last <= lat_last;
              state <= S_RUN;
            end
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_vli_encoder.sv
// Directed bench for rle_vli_encoder: hand-computed symbol streams per block pattern.
module tb_rle_vli_encoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_coef = 12'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_run;
  logic [3:0]  out_size;
  logic [10:0] out_bits;
  logic        out_is_dc;
  logic        out_last;

  int tests = 0;
  int fails = 0;
  int stalls = 0;
  int blk [64];
  logic [20:0] q [$];

  rle_vli_encoder #(.BLOCK_LEN(64)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_run(out_run), .out_size(out_size), .out_bits(out_bits),
    .out_is_dc(out_is_dc), .out_last(out_last)
  );

  always #5 clock = ~clock;

  // A symbol seen valid/ready at the falling edge transfers on the next rising edge.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready)
      q.push_back({out_run, out_size, out_bits, out_is_dc, out_last});
  end

  function automatic logic [20:0] sym(int r, int s, int b, bit dc, bit l);
    return {4'(r), 4'(s), 11'(b), dc, l};
  endfunction

  function automatic int vli_decode(logic [3:0] s, logic [10:0] b);
    if (s == 0) return 0;
    if (b[s-1]) return int'(b);
    return int'(b) - ((1 << s) - 1);
  endfunction

  task automatic send_one(input int v);
    bit ok = 0;
    in_valid = 1'b1;
    in_coef  = 12'(v);
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clock);
      if (in_ready) ok = 1;
      else stalls++;
      @(posedge clock); #1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout coef=%0d not accepted within 200 cycles", v);
    end
  endtask

  task automatic send_block();
    for (int i = 0; i < 64; i++) send_one(blk[i]);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (10) @(posedge clock);
    #1;
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_coef = 12'd5;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++;
    if ({out_run, out_size, out_bits, out_is_dc, out_last} !== 21'd0) begin
      fails++; $display("FAIL reset_outputs got %h want 0", {out_run, out_size, out_bits, out_is_dc, out_last});
    end
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
    tests++; if (q.size() !== 0) begin fails++; $display("FAIL reset_no_symbols got %0d want 0", q.size()); end
    @(posedge clock); #1;
  endtask

  task automatic test_dc_ac1();
    logic [20:0] exp [$];
    exp.push_back(sym(0, 3, 5, 1, 0));
    exp.push_back(sym(0, 1, 0, 0, 0));
    exp.push_back(sym(0, 0, 0, 0, 1));
    clear_blk(); blk[0] = 5; blk[1] = -1;
    q.delete();
    send_block(); drain();
    tests++; if (q.size() !== exp.size()) begin fails++; $display("FAIL dc_ac1_count got %0d want %0d", q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      tests++; if (q[i] !== exp[i]) begin fails++; $display("FAIL dc_ac1_sym%0d got %h want %h", i, q[i], exp[i]); end
    end
  endtask

  task automatic test_zrl_single();
    logic [20:0] exp [$];
    exp.push_back(sym(0, 2, 0, 1, 0));
    exp.push_back(sym(15, 0, 0, 0, 0));
    exp.push_back(sym(4, 3, 7, 0, 0));
    exp.push_back(sym(0, 0, 0, 0, 1));
    clear_blk(); blk[0] = -3; blk[21] = 7;
    q.delete(); stalls = 0;
    send_block(); drain();
    tests++; if (stalls !== 1) begin fails++; $display("FAIL zrl_in_ready_low got %0d cycles want 1", stalls); end
    tests++; if (q.size() !== exp.size()) begin fails++; $display("FAIL zrl_count got %0d want %0d", q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      tests++; if (q[i] !== exp[i]) begin fails++; $display("FAIL zrl_sym%0d got %h want %h", i, q[i], exp[i]); end
    end
  endtask

  task automatic test_last_nonzero();
    logic [20:0] exp [$];
    exp.push_back(sym(0, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++) exp.push_back(sym(15, 0, 0, 0, 0));
    exp.push_back(sym(14, 1, 1, 0, 1));
    clear_blk(); blk[63] = 1;
    q.delete();
    send_block(); drain();
    tests++; if (q.size() !== exp.size()) begin fails++; $display("FAIL ac63_count got %0d want %0d", q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      tests++; if (q[i] !== exp[i]) begin fails++; $display("FAIL ac63_sym%0d got %h want %h", i, q[i], exp[i]); end
    end
  endtask

  task automatic test_vli_extremes();
    logic [20:0] exp [$];
    int want [4];
    want[0] = 2047; want[1] = -2047; want[2] = -2047; want[3] = 1024;
    exp.push_back(sym(0, 0, 0, 1, 0));
    exp.push_back(sym(0, 11, 'h7FF, 0, 0));
    exp.push_back(sym(0, 11, 'h000, 0, 0));
    exp.push_back(sym(0, 11, 'h000, 0, 0));
    exp.push_back(sym(0, 11, 'h400, 0, 0));
    exp.push_back(sym(0, 0, 0, 0, 1));
    clear_blk(); blk[1] = 2047; blk[2] = -2047; blk[3] = -2048; blk[4] = 1024;
    q.delete();
    send_block(); drain();
    tests++; if (q.size() !== exp.size()) begin fails++; $display("FAIL vli_count got %0d want %0d", q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      tests++; if (q[i] !== exp[i]) begin fails++; $display("FAIL vli_sym%0d got %h want %h", i, q[i], exp[i]); end
    end
    for (int i = 0; i < 4 && i + 1 < q.size(); i++) begin
      tests++;
      if (vli_decode(q[i+1][16:13], q[i+1][12:2]) !== want[i]) begin
        fails++;
        $display("FAIL vli_roundtrip%0d got %0d want %0d", i, vli_decode(q[i+1][16:13], q[i+1][12:2]), want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [20:0] exp [$];
    exp.push_back(sym(0, 3, 5, 1, 0));
    exp.push_back(sym(0, 1, 0, 0, 0));
    exp.push_back(sym(0, 0, 0, 0, 1));
    q.delete();
    out_ready = 1'b0;
    send_one(5);
    in_coef = 12'hFFF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cycle%0d got %b want 0", c, in_ready); end
      tests++;
      if ({out_valid, out_run, out_size, out_bits, out_is_dc, out_last} !== {1'b1, sym(0, 3, 5, 1, 0)}) begin
        fails++;
        $display("FAIL bp_hold cycle%0d got %h want %h", c,
                 {out_valid, out_run, out_size, out_bits, out_is_dc, out_last}, {1'b1, sym(0, 3, 5, 1, 0)});
      end
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    send_one(-1);
    for (int i = 2; i < 64; i++) send_one(0);
    drain();
    tests++; if (q.size() !== exp.size()) begin fails++; $display("FAIL bp_count got %0d want %0d", q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      tests++; if (q[i] !== exp[i]) begin fails++; $display("FAIL bp_sym%0d got %h want %h", i, q[i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] exp [$];
    for (int b = 0; b < 2; b++) begin
      exp.push_back(sym(0, 2, 0, 1, 0));
      exp.push_back(sym(15, 0, 0, 0, 0));
      exp.push_back(sym(4, 3, 7, 0, 0));
      exp.push_back(sym(0, 0, 0, 0, 1));
    end
    clear_blk(); blk[0] = -3; blk[21] = 7;
    q.delete(); stalls = 0;
    send_block(); send_block(); drain();
    tests++; if (stalls !== 2) begin fails++; $display("FAIL b2b_stalls got %0d want 2", stalls); end
    tests++; if (q.size() !== exp.size()) begin fails++; $display("FAIL b2b_count got %0d want %0d", q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      tests++; if (q[i] !== exp[i]) begin fails++; $display("FAIL b2b_sym%0d got %h want %h", i, q[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid_block();
    logic [20:0] exp [$];
    exp.push_back(sym(0, 4, 9, 1, 0));
    exp.push_back(sym(0, 0, 0, 0, 1));
    clear_blk(); blk[0] = 1; blk[30] = 3;
    for (int i = 0; i <= 30; i++) send_one(blk[i]);
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    q.delete();
    clear_blk(); blk[0] = 9;
    send_block(); drain();
    tests++; if (q.size() !== exp.size()) begin fails++; $display("FAIL rst_mid_count got %0d want %0d", q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      tests++; if (q[i] !== exp[i]) begin fails++; $display("FAIL rst_mid_sym%0d got %h want %h", i, q[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_dc_ac1();
    test_zrl_single();
    test_last_nonzero();
    test_vli_extremes();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_block();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
